memc_dma_port: RTL and testbench
================================

Name: memc_dma_port

Overview:
Memory-controller-side responder for one lane's DMA-to-memory interface, i.e. the receiving end of the dma__memc__* / memc__dma__* signal set. It accepts DMA write and read requests and issues them to a single-port lane SRAM of fixed latency. Read data returns in order through a return FIFO that honours read_pause. It also arbitrates SRAM ownership with the SIMD load/store path using a request/grant/release handshake. One instance per PE lane, inside the PE memory controller.

Parameters:
ADDR_W, 24, DMA/SRAM word address width
DATA_W, 32, data word width
SRAM_LAT, 2, SRAM read latency in cycles (enable to data), >=1
RD_FIFO_DEPTH, 4, return FIFO entries, power of 2, >=SRAM_LAT

Ports:
clk  in  1  clock
reset_poweron  in  1  reset, asynchronous, active-low
dma__memc__write_valid  in  1  DMA write request
dma__memc__write_address  in  ADDR_W  write address
dma__memc__write_data  in  DATA_W  write data
memc__dma__write_ready  out  1  write accepted when valid&&ready
dma__memc__read_valid  in  1  DMA read request
dma__memc__read_address  in  ADDR_W  read address
dma__memc__read_pause  in  1  DMA cannot take read data this cycle
memc__dma__read_ready  out  1  read accepted when valid&&ready
memc__dma__read_data  out  DATA_W  returned data
memc__dma__read_data_valid  out  1  returned data valid
ldst__memc__request  in  1  level; load/store wants SRAM
ldst__memc__released  in  1  pulse; load/store done
memc__ldst__granted  out  1  load/store owns SRAM
ldst__memc__write_valid  in  1  load/store write (honoured only when granted)
ldst__memc__read_valid  in  1  load/store read (honoured only when granted)
ldst__memc__address  in  ADDR_W  load/store address
ldst__memc__write_data  in  DATA_W  load/store write data
memc__ldst__read_data  out  DATA_W  SRAM read data
memc__ldst__read_data_valid  out  1  SRAM_LAT after ldst read
memc__sram__enable  out  1  SRAM access strobe
memc__sram__write  out  1  1=write, 0=read
memc__sram__address  out  ADDR_W  SRAM address
memc__sram__write_data  out  DATA_W  SRAM write data
sram__memc__read_data  in  DATA_W  valid SRAM_LAT cycles after read enable

Behaviour:
- Reset (async assert, sync deassert): all outputs 0. State DMA_OWN. FIFO empty. In-flight pipe cleared. Read data in flight is discarded.
- States: DMA_OWN, DRAIN, LDST_OWN.
- DMA_OWN:
  - write_ready = !ldst__memc__request.
  - read_ready = !ldst__memc__request && !write_valid && (inflight + fifo_count < RD_FIFO_DEPTH). Writes have priority; at most one SRAM access per cycle.
  - Accepted write: SRAM write driven combinationally the same cycle (enable=1, write=1).
  - Accepted read: SRAM read driven; a valid bit enters a SRAM_LAT-deep shift pipe.
  - When the pipe bit exits, sram data is pushed into the FIFO.
  - ldst__memc__request high -> DRAIN next cycle.
- DRAIN: both readies 0. Go to LDST_OWN when inflight==0. The FIFO need not be empty; DMA keeps draining it.
- LDST_OWN:
  - granted=1 (registered, asserted on entry).
  - SRAM is driven from ldst__memc__* (write wins if both ldst valids are set).
  - ldst reads return on memc__ldst__read_data_valid SRAM_LAT cycles later, with no FIFO.
  - ldst__memc__released -> DMA_OWN next cycle, granted=0.
  - If request is still high on that DMA_OWN cycle, readies stay 0 and the state re-enters DRAIN.
- ldst__memc__* and released are ignored outside LDST_OWN.
- Read return:
  - read_data_valid = fifo_not_empty && !read_pause.
  - The FIFO pops on read_data_valid; read_data = FIFO head, combinational.
  - Push and pop in the same cycle are legal; count is unchanged.
  - The credit check makes FIFO overflow impossible. A push to a full FIFO is an assertion failure.
- Ordering: DMA reads return in acceptance order. Write-then-read to the same address returns the new data.
- inflight = popcount of the shift pipe.
- Counters: fifo_count is clog2(RD_FIFO_DEPTH)+1 bits. FIFO pointers wrap modulo depth.

Decomposition:
- Shared mem_acc_cont package holds:
  - typedef enum memc_dma_port_state_t {DMA_OWN, DRAIN, LDST_OWN};
  - MEMC_ADDR_W and MEMC_DATA_W constants, consumed as parameter defaults.
- One sub-module, memc_rd_return_fifo: a synchronous FIFO with push, pop, head, count, full and empty.

Test Plan:
- Write 0xDEADBEEF to address 0x10, then read 0x10 with pause=0 -> data_valid exactly 1+SRAM_LAT cycles after read acceptance (2+1 at defaults), data=0xDEADBEEF.
- 8 back-to-back reads to 0x0..0x7 holding 0x100+i, pause held high -> read_ready drops after 4 accepts; pause released -> 0x100..0x103 returned in order, then the remaining 4.
- write_valid and read_valid in the same cycle -> write_ready=1, read_ready=0; the read is accepted next cycle.
- 2 reads in flight, then ldst__memc__request=1 -> readies low that cycle; granted rises only after both reads land in the FIFO. ldst writes 0x55 to 0x20; release -> DMA read of 0x20 returns 0x55.
- Reset asserted with 2 reads in flight and FIFO holding 1 entry -> all outputs 0 immediately. After deassert: no stale data_valid, state DMA_OWN, read_ready=1.
- pause toggling every cycle over 4 buffered entries -> data_valid only in unpaused cycles, no entry lost or duplicated.

Source files
------------

// File: rtl/mem_acc_cont_pkg.sv
// Shared definitions for the PE memory controller: default bus widths and the
// SRAM ownership state encoding of the DMA port.
package mem_acc_cont;

    localparam int MEMC_ADDR_W = 24;
    localparam int MEMC_DATA_W = 32;

    typedef enum logic [1:0] {
        DMA_OWN  = 2'd0,
        DRAIN    = 2'd1,
        LDST_OWN = 2'd2
    } memc_dma_port_state_t;

endpackage

// File: rtl/memc_rd_return_fifo.sv
// Return FIFO for DMA read data. The head is visible combinationally so data
// leaves in the same cycle it is popped. Pointers wrap naturally (depth is a
// power of two); count carries one extra bit to tell full from empty.
module memc_rd_return_fifo
    import mem_acc_cont::*;
#(
    parameter int DATA_W = MEMC_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              do_push, do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

    // Storage: no reset needed, validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
        if (rst_n) begin
            assert (!(push && full));
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/memc_dma_port.sv
// Per-lane DMA responder in the PE memory controller. Issues DMA writes/reads
// to the lane SRAM, returns read data in order through a credit-limited FIFO,
// and hands the SRAM to the load/store path via request/grant/release.
module memc_dma_port
    import mem_acc_cont::*;
#(
    parameter int ADDR_W        = MEMC_ADDR_W,
    parameter int DATA_W        = MEMC_DATA_W,
    parameter int SRAM_LAT      = 2,
    parameter int RD_FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_poweron,
    input  logic              dma__memc__write_valid,
    input  logic [ADDR_W-1:0] dma__memc__write_address,
    input  logic [DATA_W-1:0] dma__memc__write_data,
    output logic              memc__dma__write_ready,
    input  logic              dma__memc__read_valid,
    input  logic [ADDR_W-1:0] dma__memc__read_address,
    input  logic              dma__memc__read_pause,
    output logic              memc__dma__read_ready,
    output logic [DATA_W-1:0] memc__dma__read_data,
    output logic              memc__dma__read_data_valid,
    input  logic              ldst__memc__request,
    input  logic              ldst__memc__released,
    output logic              memc__ldst__granted,
    input  logic              ldst__memc__write_valid,
    input  logic              ldst__memc__read_valid,
    input  logic [ADDR_W-1:0] ldst__memc__address,
    input  logic [DATA_W-1:0] ldst__memc__write_data,
    output logic [DATA_W-1:0] memc__ldst__read_data,
    output logic              memc__ldst__read_data_valid,
    output logic              memc__sram__enable,
    output logic              memc__sram__write,
    output logic [ADDR_W-1:0] memc__sram__address,
    output logic [DATA_W-1:0] memc__sram__write_data,
    input  logic [DATA_W-1:0] sram__memc__read_data
);

    localparam int CNT_W = $clog2(RD_FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(RD_FIFO_DEPTH);

    memc_dma_port_state_t state_reg, state_next;

    logic [SRAM_LAT-1:0] dma_pipe_reg, dma_pipe_next;
    logic [SRAM_LAT-1:0] ldst_pipe_reg, ldst_pipe_next;
    logic [CNT_W:0]      inflight;
    logic [CNT_W-1:0]    fifo_count;
    logic [DATA_W-1:0]   fifo_head;
    logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic                dma_own, ldst_own, credit_ok;
    logic                dma_wr_acc, dma_rd_acc, ldst_wr, ldst_rd;

    // Outputs are qualified with the reset so nothing toggles while it is held.
    assign dma_own  = reset_poweron && (state_reg == DMA_OWN);
    assign ldst_own = reset_poweron && (state_reg == LDST_OWN);

    // A read may only launch if its data is guaranteed a FIFO slot on return.
    assign credit_ok = ((inflight + {1'b0, fifo_count}) < DEPTH_C) && !fifo_full;

    assign memc__dma__write_ready = dma_own && !ldst__memc__request;
    assign memc__dma__read_ready  = dma_own && !ldst__memc__request
                                    && !dma__memc__write_valid && credit_ok;
    assign dma_wr_acc = dma__memc__write_valid && memc__dma__write_ready;
    assign dma_rd_acc = dma__memc__read_valid && memc__dma__read_ready;
    assign ldst_wr    = ldst_own && ldst__memc__write_valid;
    assign ldst_rd    = ldst_own && ldst__memc__read_valid && !ldst__memc__write_valid;

    assign memc__ldst__granted = ldst_own;

    // Single SRAM port: at most one of the four access sources is live per cycle.
    always_comb begin
        memc__sram__enable     = 1'b0;
        memc__sram__write      = 1'b0;
        memc__sram__address    = '0;
        memc__sram__write_data = '0;
        if (dma_wr_acc) begin
            memc__sram__enable     = 1'b1;
            memc__sram__write      = 1'b1;
            memc__sram__address    = dma__memc__write_address;
            memc__sram__write_data = dma__memc__write_data;
        end else if (dma_rd_acc) begin
            memc__sram__enable  = 1'b1;
            memc__sram__address = dma__memc__read_address;
        end else if (ldst_wr) begin
            memc__sram__enable     = 1'b1;
            memc__sram__write      = 1'b1;
            memc__sram__address    = ldst__memc__address;
            memc__sram__write_data = ldst__memc__write_data;
        end else if (ldst_rd) begin
            memc__sram__enable  = 1'b1;
            memc__sram__address = ldst__memc__address;
        end
    end

    // Latency pipes: stage 0 takes the launch, each later stage the one before.
    genvar gi;
    generate
        for (gi = 0; gi < SRAM_LAT; gi++) begin : g_pipe
            if (gi == 0) begin : g_in
                assign dma_pipe_next[gi]  = dma_rd_acc;
                assign ldst_pipe_next[gi] = ldst_rd;
            end else begin : g_shift
                assign dma_pipe_next[gi]  = dma_pipe_reg[gi-1];
                assign ldst_pipe_next[gi] = ldst_pipe_reg[gi-1];
            end
        end
    endgenerate

    // Number of DMA reads launched whose data has not yet reached the FIFO.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < SRAM_LAT; i++) begin
            inflight = inflight + (CNT_W + 1)'(dma_pipe_reg[i]);
        end
    end

    // Ownership FSM: DMA hands over only once its reads have all landed.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            DMA_OWN:  if (ldst__memc__request)  state_next = DRAIN;
            DRAIN:    if (inflight == '0)       state_next = LDST_OWN;
            LDST_OWN: if (ldst__memc__released) state_next = DMA_OWN;
            default:  state_next = DMA_OWN;
        endcase
    end

    // State and latency-pipe registers.
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            state_reg     <= DMA_OWN;
            dma_pipe_reg  <= '0;
            ldst_pipe_reg <= '0;
        end else begin
            state_reg     <= state_next;
            dma_pipe_reg  <= dma_pipe_next;
            ldst_pipe_reg <= ldst_pipe_next;
        end
    end

    assign fifo_push = dma_pipe_reg[SRAM_LAT-1];
    assign fifo_pop  = memc__dma__read_data_valid;

    memc_rd_return_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RD_FIFO_DEPTH)
    ) u_rd_fifo (
        .clk       (clk),
        .rst_n     (reset_poweron),
        .push      (fifo_push),
        .push_data (sram__memc__read_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign memc__dma__read_data_valid = !fifo_empty && !dma__memc__read_pause;
    assign memc__dma__read_data       = fifo_empty ? '0 : fifo_head;

    // Load/store reads bypass the FIFO and return straight from the SRAM.
    assign memc__ldst__read_data_valid = ldst_pipe_reg[SRAM_LAT-1];
    assign memc__ldst__read_data       = ldst_pipe_reg[SRAM_LAT-1] ? sram__memc__read_data : '0;

endmodule

// File: tb/tb_memc_dma_port.sv
// Scoreboard bench for memc_dma_port with a behavioural fixed-latency SRAM.
module tb_memc_dma_port;

    localparam int AW  = 24;
    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam int DEP = 4;

    logic          clk = 1'b0;
    logic          reset_poweron;
    logic          dma__memc__write_valid;
    logic [AW-1:0] dma__memc__write_address;
    logic [DW-1:0] dma__memc__write_data;
    logic          memc__dma__write_ready;
    logic          dma__memc__read_valid;
    logic [AW-1:0] dma__memc__read_address;
    logic          dma__memc__read_pause;
    logic          memc__dma__read_ready;
    logic [DW-1:0] memc__dma__read_data;
    logic          memc__dma__read_data_valid;
    logic          ldst__memc__request;
    logic          ldst__memc__released;
    logic          memc__ldst__granted;
    logic          ldst__memc__write_valid;
    logic          ldst__memc__read_valid;
    logic [AW-1:0] ldst__memc__address;
    logic [DW-1:0] ldst__memc__write_data;
    logic [DW-1:0] memc__ldst__read_data;
    logic          memc__ldst__read_data_valid;
    logic          memc__sram__enable;
    logic          memc__sram__write;
    logic [AW-1:0] memc__sram__address;
    logic [DW-1:0] memc__sram__write_data;
    logic [DW-1:0] sram__memc__read_data;

    always #5 clk = ~clk;

    memc_dma_port #(
        .ADDR_W(AW), .DATA_W(DW), .SRAM_LAT(LAT), .RD_FIFO_DEPTH(DEP)
    ) dut (
        .clk                         (clk),
        .reset_poweron               (reset_poweron),
        .dma__memc__write_valid      (dma__memc__write_valid),
        .dma__memc__write_address    (dma__memc__write_address),
        .dma__memc__write_data       (dma__memc__write_data),
        .memc__dma__write_ready      (memc__dma__write_ready),
        .dma__memc__read_valid       (dma__memc__read_valid),
        .dma__memc__read_address     (dma__memc__read_address),
        .dma__memc__read_pause       (dma__memc__read_pause),
        .memc__dma__read_ready       (memc__dma__read_ready),
        .memc__dma__read_data        (memc__dma__read_data),
        .memc__dma__read_data_valid  (memc__dma__read_data_valid),
        .ldst__memc__request         (ldst__memc__request),
        .ldst__memc__released        (ldst__memc__released),
        .memc__ldst__granted         (memc__ldst__granted),
        .ldst__memc__write_valid     (ldst__memc__write_valid),
        .ldst__memc__read_valid      (ldst__memc__read_valid),
        .ldst__memc__address         (ldst__memc__address),
        .ldst__memc__write_data      (ldst__memc__write_data),
        .memc__ldst__read_data       (memc__ldst__read_data),
        .memc__ldst__read_data_valid (memc__ldst__read_data_valid),
        .memc__sram__enable          (memc__sram__enable),
        .memc__sram__write           (memc__sram__write),
        .memc__sram__address         (memc__sram__address),
        .memc__sram__write_data      (memc__sram__write_data),
        .sram__memc__read_data       (sram__memc__read_data)
    );

    // Behavioural SRAM: data valid LAT cycles after a read enable.
    logic [DW-1:0] sram_mem [256];
    logic [DW-1:0] sram_rd_pipe [LAT];
    assign sram__memc__read_data = sram_rd_pipe[LAT-1];

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) sram_rd_pipe[i] <= sram_rd_pipe[i-1];
        sram_rd_pipe[0] <= (memc__sram__enable && !memc__sram__write)
                           ? sram_mem[memc__sram__address[7:0]] : 32'h0;
        if (memc__sram__enable && memc__sram__write)
            sram_mem[memc__sram__address[7:0]] <= memc__sram__write_data;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Scoreboard: reference memory plus queue of expected DMA read data.
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] sb_q [$];
    logic [DW-1:0] sb_exp;

    always @(negedge clk) begin
        if (reset_poweron) begin
            if (dma__memc__read_valid && memc__dma__read_ready)
                sb_q.push_back(ref_mem[dma__memc__read_address[7:0]]);
            if (memc__dma__read_data_valid) begin
                if (sb_q.size() == 0) begin
                    check("rd_unexpected", 1, 0);
                end else begin
                    sb_exp = sb_q.pop_front();
                    $display("[%0t] dma read return data=0x%08h exp=0x%08h", $time,
                             memc__dma__read_data, sb_exp);
                    check("rd_data", memc__dma__read_data, sb_exp);
                end
            end
            if (dma__memc__write_valid && memc__dma__write_ready)
                ref_mem[dma__memc__write_address[7:0]] = dma__memc__write_data;
            if (memc__ldst__granted && ldst__memc__write_valid)
                ref_mem[ldst__memc__address[7:0]] = ldst__memc__write_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [127:0] all_outputs();
        return {1'b0, memc__dma__write_ready, memc__dma__read_ready, memc__dma__read_data,
                memc__dma__read_data_valid, memc__ldst__granted, memc__ldst__read_data,
                memc__ldst__read_data_valid, memc__sram__enable, memc__sram__write,
                memc__sram__address, memc__sram__write_data};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, lat, cnt, viol;
        logic [DW-1:0] ldata;
        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        for (int i = 0; i < LAT; i++) sram_rd_pipe[i] = '0;
        reset_poweron = 1'b0;
        dma__memc__write_valid = 0; dma__memc__write_address = '0; dma__memc__write_data = '0;
        dma__memc__read_valid = 0;  dma__memc__read_address = '0;  dma__memc__read_pause = 0;
        ldst__memc__request = 0; ldst__memc__released = 0;
        ldst__memc__write_valid = 0; ldst__memc__read_valid = 0;
        ldst__memc__address = '0; ldst__memc__write_data = '0;

        // Reset state
        #2;
        check("reset_outputs", all_outputs(), '0);
        idle(2);
        reset_poweron = 1'b1;
        @(negedge clk);
        check("post_reset_readies", {memc__dma__write_ready, memc__dma__read_ready}, 2'b11);
        tick();

        // Write then read same address; check return latency
        dma__memc__write_valid = 1; dma__memc__write_address = 24'h10;
        dma__memc__write_data = 32'hDEADBEEF;
        @(negedge clk);
        check("wr_ready", memc__dma__write_ready, 1);
        tick();
        dma__memc__write_valid = 0;
        dma__memc__read_valid = 1; dma__memc__read_address = 24'h10;
        @(negedge clk);
        check("rd_ready", memc__dma__read_ready, 1);
        tick();
        dma__memc__read_valid = 0;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (memc__dma__read_data_valid) begin
                lat = k;
                break;
            end
            tick();
        end
        check("rd_latency", lat, 1 + LAT);
        tick();
        idle(3);

        // Preload 0..7, then 8 reads with pause held: credit stops at depth
        for (int i = 0; i < 8; i++) begin
            dma__memc__write_valid = 1; dma__memc__write_address = AW'(i);
            dma__memc__write_data = 32'h100 + DW'(i);
            tick();
        end
        dma__memc__write_valid = 0;
        dma__memc__read_pause = 1;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            dma__memc__read_valid = 1; dma__memc__read_address = AW'(acc);
            @(negedge clk);
            if (memc__dma__read_ready) acc++;
            tick();
        end
        @(negedge clk);
        check("credit_ready_low", memc__dma__read_ready, 0);
        check("credit_accepts", acc, DEP);
        tick();
        dma__memc__read_pause = 0;
        for (int c = 0; c < 40; c++) begin
            dma__memc__read_valid = (acc < 8); dma__memc__read_address = AW'(acc);
            @(negedge clk);
            if (dma__memc__read_valid && memc__dma__read_ready) acc++;
            tick();
            if (acc == 8 && sb_q.size() == 0) break;
        end
        dma__memc__read_valid = 0;
        check("burst_accepts", acc, 8);
        idle(4);

        // Simultaneous write and read: write wins, read goes next cycle
        dma__memc__write_valid = 1; dma__memc__write_address = 24'h30;
        dma__memc__write_data = 32'hCAFE0030;
        dma__memc__read_valid = 1;  dma__memc__read_address = 24'h30;
        @(negedge clk);
        check("wr_rd_collide", {memc__dma__write_ready, memc__dma__read_ready}, 2'b10);
        tick();
        dma__memc__write_valid = 0;
        @(negedge clk);
        check("rd_after_wr", memc__dma__read_ready, 1);
        tick();
        dma__memc__read_valid = 0;
        idle(6);

        // Two reads in flight, then load/store requests the SRAM
        dma__memc__read_valid = 1; dma__memc__read_address = 24'h0;
        tick();
        dma__memc__read_address = 24'h1;
        tick();
        dma__memc__read_address = 24'h2;
        ldst__memc__request = 1;
        @(negedge clk);
        check("req_readies_low", {memc__dma__write_ready, memc__dma__read_ready,
                                  memc__ldst__granted}, 3'b000);
        tick();
        dma__memc__read_valid = 0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (memc__ldst__granted) begin
                lat = k;
                break;
            end
            tick();
        end
        check("grant_delay", lat, 3);
        tick();
        ldst__memc__write_valid = 1; ldst__memc__address = 24'h20;
        ldst__memc__write_data = 32'h55;
        @(negedge clk);
        check("ldst_sram_write", {memc__sram__enable, memc__sram__write, memc__sram__address,
                                  memc__sram__write_data}, {2'b11, 24'h20, 32'h55});
        tick();
        ldst__memc__write_valid = 0;
        ldst__memc__read_valid = 1;
        tick();
        ldst__memc__read_valid = 0;
        lat = 0; ldata = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (memc__ldst__read_data_valid) begin
                lat = k;
                ldata = memc__ldst__read_data;
                break;
            end
            tick();
        end
        check("ldst_rd_latency", lat, LAT);
        check("ldst_rd_data", ldata, 32'h55);
        tick();
        ldst__memc__released = 1; ldst__memc__request = 0;
        tick();
        ldst__memc__released = 0;
        @(negedge clk);
        check("release_grant_low", {memc__ldst__granted, memc__dma__read_ready}, 2'b01);
        tick();
        dma__memc__read_valid = 1; dma__memc__read_address = 24'h20;
        @(negedge clk);
        check("rd_after_release", memc__dma__read_ready, 1);
        tick();
        dma__memc__read_valid = 0;
        idle(6);

        // Reset with reads in flight and one entry buffered
        dma__memc__read_pause = 1;
        for (int i = 4; i < 7; i++) begin
            dma__memc__read_valid = 1; dma__memc__read_address = AW'(i);
            tick();
        end
        dma__memc__read_valid = 0;
        reset_poweron = 0;
        #1;
        check("async_reset_outputs", all_outputs(), '0);
        sb_q.delete();
        idle(2);
        reset_poweron = 1;
        dma__memc__read_pause = 0;
        @(negedge clk);
        check("reset_release_readies", {memc__dma__write_ready, memc__dma__read_ready}, 2'b11);
        tick();
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (memc__dma__read_data_valid) cnt++;
            tick();
        end
        check("no_stale_valid", cnt, 0);

        // Pause toggling over four buffered entries
        dma__memc__read_pause = 1;
        acc = 0;
        for (int c = 0; c < 10 && acc < 4; c++) begin
            dma__memc__read_valid = 1; dma__memc__read_address = AW'(acc);
            @(negedge clk);
            if (memc__dma__read_ready) acc++;
            tick();
        end
        dma__memc__read_valid = 0;
        idle(4);
        cnt = 0; viol = 0;
        for (int c = 0; c < 12; c++) begin
            dma__memc__read_pause = c[0];
            @(negedge clk);
            if (memc__dma__read_data_valid) begin
                cnt++;
                if (dma__memc__read_pause) viol++;
            end
            tick();
        end
        dma__memc__read_pause = 0;
        check("pause_violations", viol, 0);
        check("pause_returns", cnt, 4);

        for (int c = 0; c < 20 && sb_q.size() != 0; c++) tick();
        check("scoreboard_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
